spart_bus_fifo_if: RTL and testbench

Buffered, parametrised processor-bus front end for the SPART. Decodes the 2-bit I/O register map on a tri-state databus and adds RX and TX FIFOs, an atomically updated baud divisor, sticky overrun flags and a maskable interrupt. It sits between the processor bus and the SPART transmitter, receiver and baud generator, replacing the unbuffered decode stage.

---
 rtl/spart_bus_fifo_if.sv | 135 +++++++++++++
 tb/tb_spart_bus_fifo_if.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_fifo_if.sv
// SPART processor-bus front end: register decode, RX/TX FIFOs,
// atomic divisor update, sticky overruns and a registered interrupt.
module spart_bus_fifo_if #(
   parameter int DATA_W   = 8,
   parameter int RX_DEPTH = 4,
   parameter int TX_DEPTH = 4,
   parameter logic [2*DATA_W-1:0] DIV_RESET = 'h0145
) (
   input  logic                clk,
   input  logic                rst_n,
   inout  wire  [DATA_W-1:0]   databus,
   input  logic [1:0]          ioaddr,
   input  logic                iocs,
   input  logic                iorw,
   input  logic                rx_valid,
   input  logic [DATA_W-1:0]   rx_data,
   input  logic                tx_ready,
   output logic                tx_load,
   output logic [DATA_W-1:0]   tx_data,
   output logic [2*DATA_W-1:0] div,
   output logic                div_load,
   output logic                irq
);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TAW = $clog2(TX_DEPTH);

   logic [DATA_W-1:0]   r_rx_mem [RX_DEPTH];
   logic [DATA_W-1:0]   r_tx_mem [TX_DEPTH];
   logic [RAW:0]        r_rx_wp, r_rx_rp;
   logic [TAW:0]        r_tx_wp, r_tx_rp;
   logic                r_rx_ovr, r_tx_ovr;
   logic [1:0]          r_ctrl;
   logic [DATA_W-1:0]   r_stage;
   logic [2*DATA_W-1:0] r_div;
   logic                r_div_load;
   logic                r_tx_load;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_irq;

   logic              w_rd, w_wr;
   logic              w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
   logic              w_rx_pop, w_rx_push, w_rx_ovf;
   logic              w_tx_push, w_tx_can, w_tx_drain, w_tx_byp;
   logic              w_tx_store, w_tx_ovf, w_stat_rd;
   logic [DATA_W-1:0] w_rdata;

   assign w_rd = iocs & iorw;
   assign w_wr = iocs & ~iorw;

   assign w_rx_empty = (r_rx_wp == r_rx_rp);
   assign w_rx_full  = (r_rx_wp[RAW] != r_rx_rp[RAW]) &&
                       (r_rx_wp[RAW-1:0] == r_rx_rp[RAW-1:0]);
   assign w_tx_empty = (r_tx_wp == r_tx_rp);
   assign w_tx_full  = (r_tx_wp[TAW] != r_tx_rp[TAW]) &&
                       (r_tx_wp[TAW-1:0] == r_tx_rp[TAW-1:0]);

   assign w_rx_pop  = w_rd & (ioaddr == 2'b00) & ~w_rx_empty;
   assign w_rx_push = rx_valid & (~w_rx_full | w_rx_pop);
   assign w_rx_ovf  = rx_valid & w_rx_full & ~w_rx_pop;
   assign w_stat_rd = w_rd & (ioaddr == 2'b01);

   // An empty FIFO with an idle transmitter forwards the write straight
   // to tx_data so the load pulse follows the push by one cycle.
   assign w_tx_push  = w_wr & (ioaddr == 2'b00);
   assign w_tx_can   = tx_ready & ~r_tx_load;
   assign w_tx_drain = ~w_tx_empty & w_tx_can;
   assign w_tx_byp   = w_tx_empty & w_tx_push & w_tx_can;
   assign w_tx_store = w_tx_push & ~w_tx_byp & (~w_tx_full | w_tx_drain);
   assign w_tx_ovf   = w_tx_push & w_tx_full & ~w_tx_drain;

   // Read mux, combinational from current state
   always_comb begin
      w_rdata = '0;
      case (ioaddr)
         2'b00: if (!w_rx_empty) w_rdata = r_rx_mem[r_rx_rp[RAW-1:0]];
         2'b01: w_rdata[4:0] = {r_tx_ovr, w_tx_empty & tx_ready,
                                r_rx_ovr, ~w_tx_full, ~w_rx_empty};
         2'b10: w_rdata = r_div[DATA_W-1:0];
         default: w_rdata = r_div[2*DATA_W-1:DATA_W];
      endcase
   end

   assign databus = w_rd ? w_rdata : {DATA_W{1'bz}};

   // FIFO storage arrays; contents are qualified by the pointers
   always_ff @(posedge clk) begin
      if (w_rx_push) r_rx_mem[r_rx_wp[RAW-1:0]] <= rx_data;
      if (w_tx_store) r_tx_mem[r_tx_wp[TAW-1:0]] <= databus;
   end

   // Pointers, flags, control, divisor and transmitter handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_rx_ovr   <= 1'b0;
         r_tx_ovr   <= 1'b0;
         r_ctrl     <= '0;
         r_stage    <= '0;
         r_div      <= DIV_RESET;
         r_div_load <= 1'b0;
         r_tx_load  <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         if (w_rx_push)  r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)   r_rx_rp <= r_rx_rp + 1'b1;
         if (w_tx_store) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_drain) r_tx_rp <= r_tx_rp + 1'b1;
         r_rx_ovr <= w_rx_ovf | (r_rx_ovr & ~w_stat_rd);
         r_tx_ovr <= w_tx_ovf | (r_tx_ovr & ~w_stat_rd);
         if (w_wr && ioaddr == 2'b01) r_ctrl <= databus[1:0];
         if (w_wr && ioaddr == 2'b10) r_stage <= databus;
         r_div_load <= w_wr & (ioaddr == 2'b11);
         if (w_wr && ioaddr == 2'b11) r_div <= {databus, r_stage};
         r_tx_load <= w_tx_drain | w_tx_byp;
         if (w_tx_drain)    r_tx_data <= r_tx_mem[r_tx_rp[TAW-1:0]];
         else if (w_tx_byp) r_tx_data <= databus;
      end
   end

   // Interrupt request, registered one cycle behind its terms
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_irq <= 1'b0;
      else        r_irq <= (r_ctrl[0] & ~w_rx_empty) |
                           (r_ctrl[1] & w_tx_empty) | r_rx_ovr | r_tx_ovr;
   end

   assign tx_load  = r_tx_load;
   assign tx_data  = r_tx_data;
   assign div      = r_div;
   assign div_load = r_div_load;
   assign irq      = r_irq;
endmodule

// File: tb/tb_spart_bus_fifo_if.sv
// Directed bench for spart_bus_fifo_if.
// Inputs change 1ns after the rising edge, outputs are sampled mid-cycle.
module tb_spart_bus_fifo_if;
   logic        clk;
   logic        rst_n;
   wire  [7:0]  databus;
   logic [7:0]  drv;
   logic        oe;
   logic [1:0]  ioaddr;
   logic        iocs;
   logic        iorw;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready;
   logic        tx_load;
   logic [7:0]  tx_data;
   logic [15:0] div;
   logic        div_load;
   logic        irq;

   int nvec = 0;
   int nerr = 0;

   assign databus = oe ? drv : 8'bz;

   spart_bus_fifo_if dut (
      .clk(clk), .rst_n(rst_n), .databus(databus), .ioaddr(ioaddr),
      .iocs(iocs), .iorw(iorw), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_load(tx_load), .tx_data(tx_data),
      .div(div), .div_load(div_load), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
      oe = 1'b0; iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #3;
      d = databus;
      tick();
      iocs = 1'b0;
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
      oe = 1'b1; drv = d; iocs = 1'b1; iorw = 1'b0; ioaddr = a;
      tick();
      iocs = 1'b0; oe = 1'b0; iorw = 1'b1;
   endtask

   task automatic rx_pulse(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      nvec++;
      if (irq !== 1'b0 || tx_load !== 1'b0 || div_load !== 1'b0) begin
         nerr++;
         $display("FAIL reset_outs: irq=%b tx_load=%b div_load=%b want 0",
                  irq, tx_load, div_load);
      end
      nvec++;
      if (div !== 16'h0145 || tx_data !== 8'h00) begin
         nerr++;
         $display("FAIL reset_div: div=%h tx_data=%h want 0145/00",
                  div, tx_data);
      end
      bus_rd(2'b00, d);
      nvec++;
      if (d !== 8'h00) begin
         nerr++; $display("FAIL reset_rd00: got %h want 00", d);
      end
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0A) begin
         nerr++; $display("FAIL reset_rd01: got %h want 0a", d);
      end
      bus_rd(2'b10, d);
      nvec++;
      if (d !== 8'h45) begin
         nerr++; $display("FAIL reset_rd10: got %h want 45", d);
      end
      bus_rd(2'b11, d);
      nvec++;
      if (d !== 8'h01) begin
         nerr++; $display("FAIL reset_rd11: got %h want 01", d);
      end
   endtask

   task automatic test_rx_fill();
      logic [7:0] d;
      logic [7:0] exp [5] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
      for (int i = 0; i < 5; i++) rx_pulse(8'h11 + 8'(i));
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0F) begin
         nerr++; $display("FAIL rx_ovr_status: got %h want 0f", d);
      end
      for (int i = 0; i < 5; i++) begin
         bus_rd(2'b00, d);
         nvec++;
         if (d !== exp[i]) begin
            nerr++; $display("FAIL rx_pop%0d: got %h want %h", i, d, exp[i]);
         end
      end
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0A) begin
         nerr++; $display("FAIL rx_ovr_clear: got %h want 0a", d);
      end
   endtask

   task automatic test_tx_drain();
      logic [7:0] d;
      logic [7:0] exp [3] = '{8'hA1, 8'hA2, 8'hA3};
      int idx = 0;
      logic prev = 1'b0;
      tx_ready = 1'b0;
      bus_wr(2'b00, 8'hA1);
      bus_wr(2'b00, 8'hA2);
      bus_wr(2'b00, 8'hA3);
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h02) begin
         nerr++; $display("FAIL tx_held_status: got %h want 02", d);
      end
      tx_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #3;
         if (tx_load) begin
            nvec++;
            if (idx > 2 || prev || tx_data !== exp[idx > 2 ? 2 : idx]) begin
               nerr++;
               $display("FAIL tx_pulse%0d: data=%h prev_load=%b", idx,
                        tx_data, prev);
            end
            idx++;
         end
         prev = tx_load;
         @(posedge clk); #1;
      end
      nvec++;
      if (idx != 3) begin
         nerr++; $display("FAIL tx_pulse_count: got %0d want 3", idx);
      end
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0A) begin
         nerr++; $display("FAIL tx_done_status: got %h want 0a", d);
      end
   endtask

   task automatic test_tx_latency();
      tx_ready = 1'b1;
      bus_wr(2'b00, 8'h5A);
      #3;
      nvec++;
      if (tx_load !== 1'b1 || tx_data !== 8'h5A) begin
         nerr++;
         $display("FAIL tx_latency: load=%b data=%h want 1/5a",
                  tx_load, tx_data);
      end
      tick();
      nvec++;
      if (tx_load !== 1'b0) begin
         nerr++; $display("FAIL tx_single: load=%b want 0", tx_load);
      end
   endtask

   task automatic test_divisor();
      logic [7:0] d;
      bus_wr(2'b10, 8'h34);
      nvec++;
      if (div !== 16'h0145 || div_load !== 1'b0) begin
         nerr++;
         $display("FAIL div_stage: div=%h load=%b want 0145/0", div, div_load);
      end
      bus_wr(2'b11, 8'h12);
      nvec++;
      if (div !== 16'h1234 || div_load !== 1'b1) begin
         nerr++;
         $display("FAIL div_apply: div=%h load=%b want 1234/1", div, div_load);
      end
      bus_rd(2'b10, d);
      nvec++;
      if (div_load !== 1'b0 || d !== 8'h34) begin
         nerr++;
         $display("FAIL div_after: load=%b lo=%h want 0/34", div_load, d);
      end
      bus_rd(2'b11, d);
      nvec++;
      if (d !== 8'h12) begin
         nerr++; $display("FAIL div_hi: got %h want 12", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      rx_valid = 1'b1; rx_data = 8'h66;
      bus_rd(2'b00, d);
      rx_valid = 1'b0;
      nvec++;
      if (d !== 8'h00) begin
         nerr++; $display("FAIL empty_pushpop: got %h want 00", d);
      end
      bus_rd(2'b00, d);
      nvec++;
      if (d !== 8'h66) begin
         nerr++; $display("FAIL empty_pushpop_kept: got %h want 66", d);
      end
      for (int i = 0; i < 4; i++) rx_pulse(8'h21 + 8'(i));
      rx_valid = 1'b1; rx_data = 8'h25;
      bus_rd(2'b00, d);
      rx_valid = 1'b0;
      nvec++;
      if (d !== 8'h21) begin
         nerr++; $display("FAIL full_pushpop: got %h want 21", d);
      end
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0B) begin
         nerr++; $display("FAIL full_pushpop_status: got %h want 0b", d);
      end
      for (int i = 0; i < 4; i++) begin
         bus_rd(2'b00, d);
         nvec++;
         if (d !== 8'h22 + 8'(i)) begin
            nerr++;
            $display("FAIL b2b_pop%0d: got %h want %h", i, d, 8'h22 + 8'(i));
         end
      end
   endtask

   task automatic test_interrupts();
      logic [7:0] d;
      bus_wr(2'b01, 8'h01);
      rx_pulse(8'h77);
      #3;
      nvec++;
      if (irq !== 1'b0) begin
         nerr++; $display("FAIL irq_lag: got %b want 0", irq);
      end
      tick();
      nvec++;
      if (irq !== 1'b1) begin
         nerr++; $display("FAIL irq_rx: got %b want 1", irq);
      end
      bus_rd(2'b00, d);
      nvec++;
      if (d !== 8'h77) begin
         nerr++; $display("FAIL irq_rx_data: got %h want 77", d);
      end
      tick();
      nvec++;
      if (irq !== 1'b0) begin
         nerr++; $display("FAIL irq_rx_clear: got %b want 0", irq);
      end
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) bus_wr(2'b00, 8'hC0 + 8'(i));
      tick();
      nvec++;
      if (irq !== 1'b1) begin
         nerr++; $display("FAIL irq_tx_ovr: got %b want 1", irq);
      end
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h10) begin
         nerr++; $display("FAIL tx_ovr_status: got %h want 10", d);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] d;
      int cnt = 0;
      int seen = 0;
      tx_ready = 1'b1;
      for (int c = 0; c < 12 && cnt < 2; c++) begin
         tick();
         if (tx_load) cnt++;
      end
      nvec++;
      if (cnt != 2) begin
         nerr++; $display("FAIL arst_setup: pulses %0d want 2", cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if (tx_load !== 1'b0 || irq !== 1'b0 || div !== 16'h0145) begin
         nerr++;
         $display("FAIL arst_immediate: load=%b irq=%b div=%h want 0/0/0145",
                  tx_load, irq, div);
      end
      #10 rst_n = 1'b1;
      tick();
      bus_rd(2'b01, d);
      nvec++;
      if (d !== 8'h0A) begin
         nerr++; $display("FAIL arst_empty: got %h want 0a", d);
      end
      for (int c = 0; c < 6; c++) begin
         #3;
         if (tx_load) seen++;
         tick();
      end
      nvec++;
      if (seen != 0) begin
         nerr++; $display("FAIL arst_no_load: pulses %0d want 0", seen);
      end
   endtask

   initial begin
      rst_n = 1'b0; oe = 1'b0; drv = '0; ioaddr = '0; iocs = 1'b0;
      iorw = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1;
      test_reset();
      test_rx_fill();
      test_tx_drain();
      test_tx_latency();
      test_divisor();
      test_back_to_back();
      test_interrupts();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
